// File: rtl/bulk_arb_pkg.sv
// Shared types and helpers for bulk_write_arbiter: round-robin pick and one-hot encode.
package bulk_arb_pkg;

    localparam int unsigned MAX_NUM_REQ = 8;
    localparam int unsigned IDX_W       = 3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // First valid index after ptr, scanning upward with wrap over n requesters.
    // Returns ptr when nothing is valid (valid[ptr] is then 0, so callers can
    // use valid[result] as "any valid").
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_NUM_REQ-1:0] valid,
        input logic [IDX_W-1:0]       ptr,
        input int unsigned            n
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!found && (i <= n) && valid[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [MAX_NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return MAX_NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/bulk_arb_out_slice.sv
// Single-entry registered output stage for bulk_write_arbiter (used with BULK_ARB_OUT_REG_EN).
module bulk_arb_out_slice #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready_c,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]    in_grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_REQ-1:0]    out_grant
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;

    // Accept a new entry whenever the stage is empty or being drained this cycle.
    assign in_ready_c = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        grant_d = grant_q;
        if (in_valid && in_ready_c) begin
            valid_d = 1'b1;
            addr_d  = in_addr;
            data_d  = in_data;
            grant_d = in_grant;
        end else if (out_ready) begin
            valid_d = 1'b0;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign out_grant = grant_q;

endmodule

// File: rtl/bulk_write_arbiter.sv
// Round-robin arbiter sharing one RAM bulk write port between NUM_REQ writers.
// Define BULK_ARB_OUT_REG_EN to insert a registered output stage (1-cycle latency).
module bulk_write_arbiter
    import bulk_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 2,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned RAM_DEPTH  = 256,
    localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                            bus_valid,
    input  logic                            bus_ready,
    output logic [ADDR_WIDTH-1:0]           bus_addr,
    output logic [DATA_WIDTH-1:0]           bus_data,
    output logic [NUM_REQ-1:0]              grant
);

    logic [MAX_NUM_REQ-1:0] valid_ext;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       winner;

    assign valid_ext = MAX_NUM_REQ'(req_valid);
    assign winner    = rr_pick(valid_ext, rr_ptr_q, NUM_REQ);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef BULK_ARB_OUT_REG_EN

    logic                  in_valid;
    logic                  in_ready_c;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REQ-1:0]    win_grant;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        in_valid  = rstn && valid_ext[winner];
        win_addr  = req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        win_data  = req_data[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
        win_grant = NUM_REQ'(onehot(winner));
        req_ready = '0;
        if (in_valid && in_ready_c) begin
            req_ready = win_grant;
            rr_ptr_d  = winner;
        end
    end

    bulk_arb_out_slice #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_slice (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready_c (in_ready_c),
        .in_addr    (win_addr),
        .in_data    (win_data),
        .in_grant   (win_grant),
        .out_valid  (bus_valid),
        .out_ready  (bus_ready),
        .out_addr   (bus_addr),
        .out_data   (bus_data),
        .out_grant  (grant)
    );

`else

    logic [0:0]            state_q,     state_d;
    logic [IDX_W-1:0]      lock_idx_q,  lock_idx_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] data_hold_q, data_hold_d;
    logic [IDX_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] mux_addr;
    logic [DATA_WIDTH-1:0] mux_data;

    // Zero-latency path; a stalled winner is frozen until its handshake or withdrawal.
    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        rr_ptr_d    = rr_ptr_q;
        addr_hold_d = addr_hold_q;
        data_hold_d = data_hold_q;

        sel       = (state_q == ST_LOCKED) ? lock_idx_q : winner;
        mux_addr  = req_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
        mux_data  = req_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
        bus_valid = rstn && valid_ext[sel];
        grant     = bus_valid ? NUM_REQ'(onehot(sel)) : '0;
        req_ready = (bus_valid && bus_ready) ? grant : '0;
        bus_addr  = bus_valid ? mux_addr : addr_hold_q;
        bus_data  = bus_valid ? mux_data : data_hold_q;

        if (bus_valid) begin
            addr_hold_d = mux_addr;
            data_hold_d = mux_data;
            if (bus_ready) begin
                state_d  = ST_IDLE;
                rr_ptr_d = sel;
            end else begin
                state_d    = ST_LOCKED;
                lock_idx_d = sel;
            end
        end else begin
            // Locked requester withdrew: release without a write, pointer untouched.
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            lock_idx_q  <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            addr_hold_q <= addr_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

`endif

endmodule

// File: tb/tb_bulk_write_arbiter.sv
// Directed self-checking bench for bulk_write_arbiter (combinational build, NUM_REQ=4).
module tb_bulk_write_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            bus_valid;
    logic            bus_ready;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_data;
    logic [N-1:0]    grant;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    bulk_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (256)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic set_payload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = '0;
        bus_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = 4'b1111;
        bus_ready = 1'b1;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready} !== 9'b0)
            $display("FAIL reset_ctrl got=%b exp=%b", {bus_valid, grant, req_ready}, 9'b0);
        else pass_cnt++;
        total_cnt++;
        if ({bus_addr, bus_data} !== 40'h0)
            $display("FAIL reset_bus got=%h exp=%h", {bus_addr, bus_data}, 40'h0);
        else pass_cnt++;
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        set_payload(0, 8'h22, 32'h13200ff0);
        req_valid = 4'b0001;
        bus_ready = 1'b1;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready, bus_addr, bus_data} !== {1'b1, 4'b0001, 4'b0001, 8'h22, 32'h13200ff0})
            $display("FAIL single_write got=%b/%b/%b/%h/%h exp=1/0001/0001/22/13200ff0",
                     bus_valid, grant, req_ready, bus_addr, bus_data);
        else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready, bus_addr, bus_data} !== {1'b0, 4'b0000, 4'b0000, 8'h22, 32'h13200ff0})
            $display("FAIL single_after got=%b/%b/%b/%h/%h exp=0/0000/0000/22/13200ff0",
                     bus_valid, grant, req_ready, bus_addr, bus_data);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [N-1:0]  exp_g;
        logic [DW-1:0] exp_d;
        do_reset();
        set_payload(0, 8'h30, 32'hAAAA0000);
        set_payload(1, 8'h31, 32'hBBBB1111);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 4'b0011;
                bus_ready = 1'b1;
            end
            #1;
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            exp_d = (k % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB1111;
            total_cnt++;
            if ({grant, req_ready, bus_data} !== {exp_g, exp_g, exp_d})
                $display("FAIL contention_%0d got=%b/%b/%h exp=%b/%b/%h",
                         k, grant, req_ready, bus_data, exp_g, exp_g, exp_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_payload(0, 8'h40, 32'hA0A0A0A0);
        set_payload(1, 8'h41, 32'hB1B1B1B1);
        @(negedge clk);
        req_valid = 4'b0010;
        bus_ready = 1'b0;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready} !== {1'b1, 4'b0010, 4'b0000})
            $display("FAIL bp_first got=%b/%b/%b exp=1/0010/0000", bus_valid, grant, req_ready);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 4'b0011;
            #1;
            total_cnt++;
            if ({grant, req_ready, bus_addr, bus_data} !== {4'b0010, 4'b0000, 8'h41, 32'hB1B1B1B1})
                $display("FAIL bp_stall_%0d got=%b/%b/%h/%h exp=0010/0000/41/b1b1b1b1",
                         k, grant, req_ready, bus_addr, bus_data);
            else pass_cnt++;
        end
        @(negedge clk);
        bus_ready = 1'b1;
        #1;
        total_cnt++;
        if ({grant, req_ready} !== {4'b0010, 4'b0010})
            $display("FAIL bp_release got=%b/%b exp=0010/0010", grant, req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        total_cnt++;
        if ({grant, req_ready, bus_addr} !== {4'b0001, 4'b0001, 8'h40})
            $display("FAIL bp_next got=%b/%b/%h exp=0001/0001/40", grant, req_ready, bus_addr);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) set_payload(i, 8'(8'h50 + i), 32'(32'hC0DE0000 + i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 4'b1111;
                bus_ready = 1'b1;
            end
            #1;
            exp_g = 4'b0001 << (k % 4);
            total_cnt++;
            if (grant !== exp_g)
                $display("FAIL wrap_%0d got=%b exp=%b", k, grant, exp_g);
            else pass_cnt++;
        end
    endtask

    task automatic test_drop_lock();
        do_reset();
        set_payload(0, 8'h60, 32'h60606060);
        set_payload(1, 8'h61, 32'h61616161);
        @(negedge clk);
        req_valid = 4'b0010;
        bus_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready} !== 9'b0)
            $display("FAIL drop_same_cycle got=%b/%b/%b exp=0/0000/0000", bus_valid, grant, req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = 4'b0011;
        bus_ready = 1'b1;
        #1;
        total_cnt++;
        if ({grant, bus_data} !== {4'b0001, 32'h60606060})
            $display("FAIL drop_unlocked got=%b/%h exp=0001/60606060", grant, bus_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_payload(0, 8'h70, 32'h70707070);
        set_payload(1, 8'h71, 32'h71717171);
        @(negedge clk);
        req_valid = 4'b0010;
        bus_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        total_cnt++;
        if (grant !== 4'b0010)
            $display("FAIL rst_mid_locked got=%b exp=0010", grant);
        else pass_cnt++;
        #2;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready, bus_addr, bus_data} !== 49'h0)
            $display("FAIL rst_mid_zero got=%b/%b/%b/%h/%h exp=0/0000/0000/00/00000000",
                     bus_valid, grant, req_ready, bus_addr, bus_data);
        else pass_cnt++;
        @(negedge clk);
        rstn      = 1'b1;
        bus_ready = 1'b1;
        #1;
        total_cnt++;
        if ({grant, bus_data} !== {4'b0001, 32'h70707070})
            $display("FAIL rst_mid_first got=%b/%h exp=0001/70707070", grant, bus_data);
        else pass_cnt++;
    endtask

    task automatic test_idle_gap();
        // Continues from test_reset_mid: requester 0 was just served, so rr_ptr = 0.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = '0;
            #1;
            total_cnt++;
            if ({bus_valid, grant, req_ready} !== 9'b0)
                $display("FAIL idle_%0d got=%b/%b/%b exp=0/0000/0000", k, bus_valid, grant, req_ready);
            else pass_cnt++;
        end
        @(negedge clk);
        req_valid = 4'b0011;
        #1;
        total_cnt++;
        if ({bus_valid, grant, req_ready, bus_addr} !== {1'b1, 4'b0010, 4'b0010, 8'h71})
            $display("FAIL idle_resume got=%b/%b/%b/%h exp=1/0010/0010/71",
                     bus_valid, grant, req_ready, bus_addr);
        else pass_cnt++;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        bus_ready = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_drop_lock();
        test_reset_mid();
        test_idle_gap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
